apb_requester_engine: RTL and testbench

APB_REQUESTER_ENGINE -- requirements
Module: apb_requester_engine

---
 rtl/apb_requester_pkg.sv | 23 ++
 rtl/apb_if.sv | 33 +++
 rtl/apb_timeout_counter.sv | 33 +++
 rtl/apb_requester_engine.sv | 124 ++++++++++++
 tb/tb_apb_requester_engine.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_requester_pkg.sv
// Shared types for the APB requester engine: FSM state encoding, response
// record and the timeout-counter width helper.
package apb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } rsp_t;

    // A zero-cycle timeout still needs a one-bit register to stay legal.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle. The requester owns clock/reset distribution and the request
// signals; the completer returns data, ready and error.
interface APB #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int USER_WIDTH = 0
);
    localparam int USER_W = (USER_WIDTH > 0) ? USER_WIDTH : 1;

    logic                    pclk;
    logic                    preset_n;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic [USER_W-1:0]       pauser;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport requester (
        output pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot, pauser,
        input  prdata, pready, pslverr
    );

    modport completer (
        input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot, pauser,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timeout_counter.sv
// Saturating ACCESS-phase wait counter; o_expired flags the last allowed
// wait cycle. TIMEOUT_CYCLES = 0 never expires.
module apb_timeout_counter
    import apb_requester_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int               CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && (r_count == LIMIT);

endmodule

// File: rtl/apb_requester_engine.sv
// Single-outstanding command-to-APB bridge: IDLE -> SETUP -> ACCESS -> RESP,
// with an ACCESS-phase timeout that aborts a stalled completer.
module apb_requester_engine
    import apb_requester_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    APB.requester                 apb
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_cmd_ready;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_strb;
    rsp_t                  r_rsp;
    logic                  w_cmd_fire;
    logic                  w_expired;
    logic                  w_wait;

    assign w_cmd_fire = cmd_valid && r_cmd_ready;
    assign w_wait     = (r_state == ACCESS) && !apb.pready;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (pclk),
        .rst_n     (preset_n),
        .i_clear   (r_state == SETUP),
        .i_enable  (w_wait),
        .o_expired (w_expired)
    );

    // NOTE: the next-state value is defaulted before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_cmd_fire) w_next_state = SETUP;
            SETUP:   w_next_state = ACCESS;
            ACCESS:  if (apb.pready || w_expired) w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // cmd_ready is registered so it stays low through reset and rises on the
    // first edge after release, never in the response handshake cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_ready <= (w_next_state == IDLE);
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_cmd_fire) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr & ADDR_MASK;
            r_wdata <= cmd_wdata;
            r_strb  <= cmd_write ? cmd_strb : 4'h0;
        end
    end

    // pready wins over timeout expiry in the same cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_rsp <= '0;
        end else if (r_state == ACCESS) begin
            if (apb.pready) begin
                r_rsp.rdata   <= r_write ? 32'h0 : apb.prdata;
                r_rsp.err     <= apb.pslverr;
                r_rsp.timeout <= 1'b0;
            end else if (w_expired) begin
                r_rsp.rdata   <= 32'h0;
                r_rsp.err     <= 1'b1;
                r_rsp.timeout <= 1'b1;
            end
        end
    end

    assign apb.pclk     = pclk;
    assign apb.preset_n = preset_n;
    assign apb.psel     = (r_state == SETUP) || (r_state == ACCESS);
    assign apb.penable  = (r_state == ACCESS);
    assign apb.paddr    = r_addr;
    assign apb.pwrite   = r_write;
    assign apb.pwdata   = r_wdata;
    assign apb.pstrb    = r_strb;
    assign apb.pprot    = 3'b000;
    assign apb.pauser   = '0;

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = (r_state == RESP);
    assign rsp_rdata   = r_rsp.rdata;
    assign rsp_err     = r_rsp.err;
    assign rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_requester_engine.sv
// Self-checking bench: directed and randomized commands against a behavioural
// completer and a rule-level model of the expected response and bus timing.
module tb_apb_requester_engine;
    localparam int T = 8;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int checks   = 0;
    int failures = 0;

    APB #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .USER_WIDTH(0)) apb_bus ();

    apb_requester_engine #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (apb_bus)
    );

    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Completer behaviour for the current transaction and the values the bus
    // must carry while psel is high.
    int          cur_wait  = 0;
    logic [31:0] cur_rdata = 32'h0;
    logic        cur_err   = 1'b0;
    logic [31:0] exp_paddr  = 32'h0;
    logic        exp_pwrite = 1'b0;
    logic [31:0] exp_pwdata = 32'h0;
    logic [3:0]  exp_pstrb  = 4'h0;

    int acc_k       = 0;
    int setup_seen  = 0;
    int access_seen = 0;
    int apb_bad     = 0;

    always @(negedge pclk) begin
        if (apb_bus.psel === 1'b1) begin
            if (apb_bus.paddr !== exp_paddr || apb_bus.pwrite !== exp_pwrite ||
                apb_bus.pstrb !== exp_pstrb || apb_bus.pprot !== 3'b000 ||
                (exp_pwrite && apb_bus.pwdata !== exp_pwdata))
                apb_bad++;
        end
        if (apb_bus.psel === 1'b1 && apb_bus.penable === 1'b1) begin
            access_seen++;
            apb_bus.pready  = (acc_k == cur_wait);
            apb_bus.prdata  = (acc_k == cur_wait) ? cur_rdata : $urandom;
            apb_bus.pslverr = (acc_k == cur_wait) ? cur_err : 1'b1;
            acc_k++;
        end else begin
            if (apb_bus.psel === 1'b1) setup_seen++;
            apb_bus.pready  = 1'b0;
            apb_bus.prdata  = $urandom;
            apb_bus.pslverr = 1'b0;
            acc_k = 0;
        end
    end

    typedef struct packed {
        int          access_cycles;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    // A completer that waits T or more cycles is cut off after T ACCESS cycles.
    function automatic exp_t model(input logic wr, input int wait_n, input logic [31:0] rd, input logic er);
        exp_t e;
        if (wait_n >= T) begin
            e.access_cycles = T;
            e.rdata = 32'h0;
            e.err   = 1'b1;
            e.tmo   = 1'b1;
        end else begin
            e.access_cycles = wait_n + 1;
            e.rdata = wr ? 32'h0 : rd;
            e.err   = er;
            e.tmo   = 1'b0;
        end
        return e;
    endfunction

    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input int wait_n,
                           input logic [31:0] rd, input logic er, input int hold);
        exp_t e;
        int   s0, a0, b0, lat;
        bit   got;
        e = model(wr, wait_n, rd, er);
        exp_paddr  = addr & 32'hFFFF_FFFC;
        exp_pwrite = wr;
        exp_pwdata = wdata;
        exp_pstrb  = wr ? strb : 4'h0;
        cur_wait   = wait_n;
        cur_rdata  = rd;
        cur_err    = er;
        s0 = setup_seen;
        a0 = access_seen;
        b0 = apb_bad;

        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        check({name, ":accept"}, 64'(got), 64'd1);
        if (!got) begin
            cmd_valid = 1'b0;
            return;
        end

        @(negedge pclk);
        cmd_valid = 1'b0;
        lat = 1;
        check({name, ":setup"}, {apb_bus.psel, apb_bus.penable, cmd_ready}, 3'b100);

        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            lat++;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({name, ":rsp_seen"}, 64'(got), 64'd1);
        if (!got) return;
        check({name, ":latency"}, 64'(lat), 64'(2 + e.access_cycles));
        check({name, ":setup_cycles"}, 64'(setup_seen - s0), 64'd1);
        check({name, ":access_cycles"}, 64'(access_seen - a0), 64'(e.access_cycles));
        check({name, ":bus_stable"}, 64'(apb_bad - b0), 64'd0);

        // A second command offered during RESP must not be taken.
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check({name, ":resp_hold"},
                  {rsp_valid, cmd_ready, apb_bus.psel, rsp_rdata, rsp_err, rsp_timeout},
                  {3'b100, e.rdata, e.err, e.tmo});
            cmd_valid = 1'b1;
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        check({name, ":resp"},
              {rsp_valid, cmd_ready, apb_bus.psel, rsp_rdata, rsp_err, rsp_timeout},
              {3'b100, e.rdata, e.err, e.tmo});
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check({name, ":after_rsp"}, {rsp_valid, cmd_ready, apb_bus.psel}, 3'b010);
    endtask

    initial begin
        bit got;
        preset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset:ctl", {apb_bus.psel, apb_bus.penable, apb_bus.pwrite, cmd_ready,
                            rsp_valid, rsp_err, rsp_timeout}, 7'h0);
        check("reset:paddr", apb_bus.paddr, 32'h0);
        preset_n = 1'b1;
        #1;
        check("release:no_edge_yet", cmd_ready, 1'b0);
        @(negedge pclk);
        check("release:first_edge", cmd_ready, 1'b1);

        run_txn("wr_0ws",   1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 4'hF, 0,   32'h0,         1'b0, 0);
        run_txn("rd_5ws",   1'b0, 32'h0000_0C00, 32'h1111_2222, 4'hF, 5,   32'h1234_5678, 1'b0, 2);
        run_txn("wr_slverr",1'b1, 32'h0000_0010, 32'h0F0F_0F0F, 4'h3, 2,   32'h0,         1'b1, 4);
        run_txn("rd_slverr",1'b0, 32'h0000_0020, 32'h0,         4'h0, 0,   32'hCAFE_F00D, 1'b1, 1);
        run_txn("rd_tmo",   1'b0, 32'h0000_0040, 32'h0,         4'h0, 100, 32'h7777_7777, 1'b0, 1);
        run_txn("rd_8th",   1'b0, 32'h0000_0044, 32'h0,         4'h0, T-1, 32'h0BAD_CAFE, 1'b0, 0);
        run_txn("wr_tmo9",  1'b1, 32'h0000_0048, 32'h5555_AAAA, 4'h9, T,   32'h0,         1'b0, 0);
        run_txn("wr_unalgn",1'b1, 32'h0000_1237, 32'h1357_9BDF, 4'h6, 1,   32'h0,         1'b0, 0);
        run_txn("rd_bp10",  1'b0, 32'h0000_2000, 32'h0,         4'h0, 3,   32'hA1B2_C3D4, 1'b0, 10);

        // Reset pulsed in the middle of a stalled ACCESS phase.
        exp_paddr  = 32'h0000_0888;
        exp_pwrite = 1'b1;
        exp_pwdata = 32'h55AA_33CC;
        exp_pstrb  = 4'h5;
        cur_wait   = 1000;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0888;
        cmd_wdata = 32'h55AA_33CC;
        cmd_strb  = 4'h5;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        check("rst_txn:accept", 64'(got), 64'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_txn:in_access", {apb_bus.psel, apb_bus.penable}, 2'b11);
        preset_n = 1'b0;
        #1;
        check("rst_mid:ctl", {apb_bus.psel, apb_bus.penable, apb_bus.pwrite, cmd_ready,
                              rsp_valid, rsp_err, rsp_timeout}, 7'h0);
        check("rst_mid:paddr", apb_bus.paddr, 32'h0);
        check("rst_mid:pwdata", apb_bus.pwdata, 32'h0);
        check("rst_mid:pstrb", apb_bus.pstrb, 4'h0);
        check("rst_mid:rsp_rdata", rsp_rdata, 32'h0);
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;
        #1;
        check("rst_rel:no_edge_yet", cmd_ready, 1'b0);
        @(negedge pclk);
        check("rst_rel:first_edge", {cmd_ready, rsp_valid, apb_bus.psel}, 3'b100);
        repeat (3) @(negedge pclk);
        check("rst_rel:no_rsp", {cmd_ready, rsp_valid, apb_bus.psel}, 3'b100);

        for (int n = 0; n < 24; n++) begin
            logic        wr;
            logic [31:0] addr, wdata, rd;
            logic [3:0]  strb;
            int          wait_n, hold;
            logic        er;
            wr     = 1'($urandom);
            addr   = $urandom;
            wdata  = $urandom;
            rd     = $urandom;
            strb   = 4'($urandom);
            wait_n = int'($urandom_range(0, 10));
            hold   = int'($urandom_range(0, 3));
            er     = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rand%0d", n), wr, addr, wdata, strb, wait_n, rd, er, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
